// File: rtl/accum_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | accum_seq_pkg: shared types and helpers for the accumulator    |
// | sequencing controller.                        Revision: 1.0    |
// +----------------------------------------------------------------+
package accum_seq_pkg;

  localparam int DW_DEFAULT  = 8;
  localparam int OPW_DEFAULT = 4;
  localparam int CNT_MAX     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef logic [1:0] argc_t;

  // A zero operand count still needs one operand.
  function automatic argc_t argc_norm(input argc_t argc);
    return (argc == 2'd0) ? 2'd1 : argc;
  endfunction

  function automatic logic [1:0] popcount3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/accum_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | accum_seq_timer: loadable down-counter with expired flag.      |
// |                                               Revision: 1.0    |
// +----------------------------------------------------------------+
module accum_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/accum_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | accum_seq_ctrl: sequences operand pushes and ALU operations    |
// | for the 3-entry operand accumulator.          Revision: 1.0    |
// +----------------------------------------------------------------+
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int OPW     = OPW_DEFAULT,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_req,
  input  logic [DW-1:0]   push_value,
  input  logic            op_req,
  input  logic [OPW-1:0]  op_code,
  input  logic [1:0]      op_argc,
  output logic            ready,
  output logic            stall,
  output logic            acc_put_en,
  output logic [DW-1:0]   acc_value,
  output logic            acc_op_en,
  input  logic            r0_valid,
  input  logic            r1_valid,
  input  logic            r2_valid,
  output logic            alu_start,
  output logic [OPW-1:0]  alu_opcode,
  input  logic            alu_done,
  output logic            err_overflow,
  output logic            err_underflow,
  output logic            err_timeout,
  output logic            err_sync,
  input  logic            err_clr,
  output logic [CNTW-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic            put_en_q, put_en_d;
  logic [DW-1:0]   value_q, value_d;
  logic            op_en_q, op_en_d;
  logic            start_q, start_d;
  logic            done_ok_q, done_ok_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;
  logic            err_tmo_q, err_tmo_d;
  logic            err_sync_q, err_sync_d;
  logic            set_ovf, set_unf, set_tmo, set_sync;
  logic            timer_load, timer_en, timer_expired;

  assign timer_load = (state_q == ST_ISSUE);
  assign timer_en   = (state_q == ST_BUSY);

  // Loaded with TIMEOUT-1 so BUSY lasts at most TIMEOUT cycles.
  accum_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (TW'(TIMEOUT - 1)),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    put_en_d   = 1'b0;
    value_d    = value_q;
    op_en_d    = 1'b0;
    start_d    = 1'b0;
    done_ok_d  = done_ok_q;
    op_count_d = op_count_q;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    set_tmo    = 1'b0;
    set_sync   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_req) begin
          if (cnt_q >= argc_norm(op_argc)) begin
            opcode_d = op_code;
            start_d  = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            set_unf = 1'b1;
          end
        end else if (push_req) begin
          if (cnt_q != 2'(CNT_MAX)) begin
            put_en_d = 1'b1;
            value_d  = push_value;
            cnt_d    = cnt_q + 2'd1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        set_sync = (popcount3(r0_valid, r1_valid, r2_valid) != cnt_q);
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        if (alu_done) begin
          op_en_d   = 1'b1;
          done_ok_d = 1'b1;
          state_d   = ST_FLUSH;
        end else if (timer_expired) begin
          op_en_d   = 1'b1;
          done_ok_d = 1'b0;
          set_tmo   = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_d = 2'd0;
        if (done_ok_q) begin
          op_count_d = op_count_q + CNTW'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flag raised this cycle takes precedence over a simultaneous clear.
    err_ovf_d  = set_ovf  | (err_ovf_q  & ~err_clr);
    err_unf_d  = set_unf  | (err_unf_q  & ~err_clr);
    err_tmo_d  = set_tmo  | (err_tmo_q  & ~err_clr);
    err_sync_d = set_sync | (err_sync_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      opcode_q   <= '0;
      put_en_q   <= 1'b0;
      value_q    <= '0;
      op_en_q    <= 1'b0;
      start_q    <= 1'b0;
      done_ok_q  <= 1'b0;
      op_count_q <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      put_en_q   <= put_en_d;
      value_q    <= value_d;
      op_en_q    <= op_en_d;
      start_q    <= start_d;
      done_ok_q  <= done_ok_d;
      op_count_q <= op_count_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_tmo_q  <= err_tmo_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign stall         = ~ready;
  assign acc_put_en    = put_en_q;
  assign acc_value     = value_q;
  assign acc_op_en     = op_en_q;
  assign alu_start     = start_q;
  assign alu_opcode    = opcode_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_timeout   = err_tmo_q;
  assign err_sync      = err_sync_q;
  assign op_count      = op_count_q;

endmodule
`default_nettype wire
